mcb_bst_seq: RTL and testbench

- Burst sequencer that sits directly upstream of the MCB command FSM.
- Accepts one host transfer request (bank/row/column start, direction, number of bursts) and holds the address context for the transfer.
- Drives mcb_bb, c_bst_dir and c_bst_last into the command FSM and advances the column/row pointers on each issued RD/WR/RDA/WRA pulse.
- Splits transfers at row boundaries into separate ACT…xxA sequences.

---
 rtl/mcb_bst_seq.sv | 140 ++++++++++++++
 tb/tb_mcb_bst_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcb_bst_seq.sv
// rtl/mcb_bst_seq.sv - burst sequencer feeding the MCB command FSM
module mcb_bst_seq #(
  parameter int BANK_W = 2,
  parameter int ROW_W  = 13,
  parameter int COL_W  = 9,
  parameter int LEN_W  = 8,
  parameter int pBL    = 4
) (
  input  logic              mcb_clk,
  input  logic              mcb_rst_n,
  input  logic              mcb_sclr_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_dir,
  input  logic [BANK_W-1:0] req_bank,
  input  logic [ROW_W-1:0]  req_row,
  input  logic [COL_W-1:0]  req_col,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              c_rd,
  input  logic              c_wr,
  input  logic              c_rda,
  input  logic              c_wra,
  output logic              mcb_bb,
  output logic              c_bst_dir,
  output logic              c_bst_last,
  output logic [BANK_W-1:0] c_bank,
  output logic [ROW_W-1:0]  c_row,
  output logic [COL_W-1:0]  c_col,
  output logic              req_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Word offset bits inside one burst, and the column advance per burst.
  localparam logic [COL_W-1:0] COL_LOW  = COL_W'(pBL - 1);
  localparam logic [COL_W-1:0] COL_STEP = COL_W'(pBL);

  state_t              state_q, state_d;
  logic                dir_q, dir_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [LEN_W-1:0]    rem_q, rem_d;

  logic                burst_last;
  logic                close_pulse;
  logic                plain_pulse;
  logic [LEN_W-1:0]    rem_dec;

  // Last burst of the transfer, or last burst slot of the current row.
  assign burst_last  = (rem_q == LEN_W'(1)) | (&(col_q | COL_LOW));
  // A plain pulse arriving on a last burst is handled as its auto-precharge form.
  assign close_pulse = c_rda | c_wra | ((c_rd | c_wr) & burst_last);
  assign plain_pulse = c_rd | c_wr;
  // Saturating decrement: rem never wraps below zero.
  assign rem_dec     = (rem_q != '0) ? (rem_q - 1'b1) : rem_q;

  assign req_ready  = (state_q == S_IDLE) & mcb_sclr_n;
  assign mcb_bb     = (state_q == S_BUSY);
  assign req_done   = (state_q == S_DONE);
  assign c_bst_last = (state_q == S_BUSY) & burst_last;
  assign c_bst_dir  = dir_q;
  assign c_bank     = bank_q;
  assign c_row      = row_q;
  assign c_col      = col_q;

  // Next-state and address-context update.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    bank_d  = bank_q;
    row_d   = row_q;
    col_d   = col_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          dir_d   = req_dir;
          bank_d  = req_bank;
          row_d   = req_row;
          col_d   = req_col & ~COL_LOW;
          rem_d   = req_len;
          state_d = (req_len != '0) ? S_BUSY : S_DONE;
        end
      end
      S_BUSY: begin
        if (close_pulse) begin
          rem_d = rem_dec;
          if (rem_dec == '0) begin
            state_d = S_DONE;
          end else begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end
        end else if (plain_pulse) begin
          col_d = col_q + COL_STEP;
          rem_d = rem_dec;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (!mcb_sclr_n) begin
      state_d = S_IDLE;
      dir_d   = 1'b0;
      bank_d  = '0;
      row_d   = '0;
      col_d   = '0;
      rem_d   = '0;
    end
  end

  // State and context registers with asynchronous reset.
  always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
    if (!mcb_rst_n) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      bank_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      bank_q  <= bank_d;
      row_q   <= row_d;
      col_q   <= col_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_mcb_bst_seq.sv
// tb/tb_mcb_bst_seq.sv - self-checking bench for mcb_bst_seq
module tb_mcb_bst_seq;

  localparam int BANK_W = 2;
  localparam int ROW_W  = 13;
  localparam int COL_W  = 9;
  localparam int LEN_W  = 8;
  localparam int pBL    = 4;
  localparam int NCOL   = 1 << COL_W;
  localparam int NROW   = 1 << ROW_W;

  logic              mcb_clk;
  logic              mcb_rst_n;
  logic              mcb_sclr_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_dir;
  logic [BANK_W-1:0] req_bank;
  logic [ROW_W-1:0]  req_row;
  logic [COL_W-1:0]  req_col;
  logic [LEN_W-1:0]  req_len;
  logic              c_rd, c_wr, c_rda, c_wra;
  logic              mcb_bb;
  logic              c_bst_dir;
  logic              c_bst_last;
  logic [BANK_W-1:0] c_bank;
  logic [ROW_W-1:0]  c_row;
  logic [COL_W-1:0]  c_col;
  logic              req_done;

  int checks = 0;
  int errors = 0;

  mcb_bst_seq #(
    .BANK_W(BANK_W), .ROW_W(ROW_W), .COL_W(COL_W), .LEN_W(LEN_W), .pBL(pBL)
  ) dut (
    .mcb_clk(mcb_clk), .mcb_rst_n(mcb_rst_n), .mcb_sclr_n(mcb_sclr_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
    .req_bank(req_bank), .req_row(req_row), .req_col(req_col), .req_len(req_len),
    .c_rd(c_rd), .c_wr(c_wr), .c_rda(c_rda), .c_wra(c_wra),
    .mcb_bb(mcb_bb), .c_bst_dir(c_bst_dir), .c_bst_last(c_bst_last),
    .c_bank(c_bank), .c_row(c_row), .c_col(c_col), .req_done(req_done)
  );

  initial mcb_clk = 1'b0;
  always #5 mcb_clk = ~mcb_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge mcb_clk);
    #1;
  endtask

  // Present a request and wait (bounded) until it is taken.
  task automatic issue_req(input logic dir, input int bank, input int row, input int col, input int len);
    int n;
    req_dir   = dir;
    req_bank  = BANK_W'(bank);
    req_row   = ROW_W'(row);
    req_col   = COL_W'(col);
    req_len   = LEN_W'(len);
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait: req_ready=%b after %0d cycles, required 1", req_ready, n);
    end
    step();
    req_valid = 1'b0;
  endtask

  // Act as the command FSM: issue every burst the model expects and check the context.
  task automatic drive_bursts(input logic dir, input int bank, input int row, input int col, input int len);
    int r, c, gap;
    bit exp_last;
    logic [28:0] obs, expv;
    r = row;
    c = (col / pBL) * pBL;
    for (int k = 0; k < len; k++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        checks++;
        if ({mcb_bb, req_ready, req_done} !== 3'b100) begin
          errors++;
          $display("FAIL busy_gap: bb/ready/done=%b, required 100", {mcb_bb, req_ready, req_done});
        end
        step();
      end
      exp_last = (k == len - 1) || (c + pBL >= NCOL);
      obs  = {mcb_bb, req_ready, req_done, c_bst_dir, c_bank, c_row, c_col, c_bst_last};
      expv = {1'b1, 1'b0, 1'b0, dir, BANK_W'(bank), ROW_W'(r), COL_W'(c), exp_last};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL burst_ctx k=%0d: bb,rdy,done,dir,bank,row,col,last got %h required %h", k, obs, expv);
      end
      if (exp_last) begin
        c_rda = dir;
        c_wra = !dir;
      end else begin
        c_rd = dir;
        c_wr = !dir;
      end
      step();
      {c_rd, c_wr, c_rda, c_wra} = 4'b0000;
      if (exp_last && k < len - 1) begin
        r = (r + 1) % NROW;
        c = 0;
      end else begin
        c = c + pBL;
      end
    end
    checks++;
    if ({mcb_bb, req_done, req_ready} !== 3'b010) begin
      errors++;
      $display("FAIL done_pulse: bb/done/ready=%b, required 010", {mcb_bb, req_done, req_ready});
    end
    step();
    checks++;
    if ({mcb_bb, req_done, req_ready} !== 3'b001) begin
      errors++;
      $display("FAIL after_done: bb/done/ready=%b, required 001", {mcb_bb, req_done, req_ready});
    end
  endtask

  task automatic run_xfer(input logic dir, input int bank, input int row, input int col, input int len);
    issue_req(dir, bank, row, col, len);
    drive_bursts(dir, bank, row, col, len);
  endtask

  task automatic test_reset();
    mcb_rst_n  = 1'b0;
    mcb_sclr_n = 1'b1;
    req_valid  = 1'b0;
    req_dir = 1'b0; req_bank = '0; req_row = '0; req_col = '0; req_len = '0;
    {c_rd, c_wr, c_rda, c_wra} = 4'b0000;
    repeat (3) step();
    mcb_rst_n = 1'b1;
    step();
    checks++;
    if ({mcb_bb, req_done, c_bst_dir, c_bst_last, c_bank, c_row, c_col} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {mcb_bb, req_done, c_bst_dir, c_bst_last, c_bank, c_row, c_col});
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b required 1", req_ready);
    end
  endtask

  task automatic test_directed();
    run_xfer(1'b1, 1, 'h0100, 'h010, 1);
    run_xfer(1'b0, 2, 'h0033, 'h008, 3);
    run_xfer(1'b0, 3, 'h1FFF, 'h1F8, 4);
    run_xfer(1'b1, 0, 'h0042, 'h013, 2);
  endtask

  task automatic test_zero_len();
    issue_req(1'b1, 2, 'h0777, 'h0A4, 0);
    checks++;
    if ({mcb_bb, req_done, req_ready} !== 3'b010) begin
      errors++;
      $display("FAIL zero_len_done: bb/done/ready=%b required 010", {mcb_bb, req_done, req_ready});
    end
    step();
    checks++;
    if ({mcb_bb, req_done, req_ready} !== 3'b001) begin
      errors++;
      $display("FAIL zero_len_idle: bb/done/ready=%b required 001", {mcb_bb, req_done, req_ready});
    end
  endtask

  task automatic test_idle_pulses();
    c_rda = 1'b1;
    step();
    c_rda = 1'b0;
    c_wr  = 1'b1;
    step();
    c_wr  = 1'b0;
    checks++;
    if ({mcb_bb, req_done, req_ready} !== 3'b001) begin
      errors++;
      $display("FAIL idle_pulses: bb/done/ready=%b required 001", {mcb_bb, req_done, req_ready});
    end
    run_xfer(1'b0, 1, 'h0200, 'h1F0, 6);
  endtask

  task automatic test_abort();
    issue_req(1'b1, 2, 'h0055, 'h040, 8);
    repeat (3) begin
      c_rd = 1'b1;
      step();
      c_rd = 1'b0;
    end
    checks++;
    if ({mcb_bb, c_col} !== {1'b1, COL_W'('h04C)}) begin
      errors++;
      $display("FAIL abort_pre: bb/col=%h required %h", {mcb_bb, c_col}, {1'b1, COL_W'('h04C)});
    end
    mcb_sclr_n = 1'b0;
    step();
    checks++;
    if ({mcb_bb, req_ready, req_done, c_bst_dir, c_bst_last, c_bank, c_row, c_col} !== '0) begin
      errors++;
      $display("FAIL abort_clear: got %h required 0",
               {mcb_bb, req_ready, req_done, c_bst_dir, c_bst_last, c_bank, c_row, c_col});
    end
    mcb_sclr_n = 1'b1;
    repeat (4) begin
      step();
      checks++;
      if ({mcb_bb, req_done, req_ready} !== 3'b001) begin
        errors++;
        $display("FAIL abort_no_done: bb/done/ready=%b required 001", {mcb_bb, req_done, req_ready});
      end
    end
  endtask

  task automatic test_back_to_back();
    issue_req(1'b0, 1, 'h0123, 'h100, 5);
    req_dir   = 1'b1;
    req_bank  = BANK_W'(3);
    req_row   = ROW_W'('h0456);
    req_col   = COL_W'('h1FC);
    req_len   = LEN_W'(2);
    req_valid = 1'b1;
    drive_bursts(1'b0, 1, 'h0123, 'h100, 5);
    run_xfer(1'b1, 3, 'h0456, 'h1FC, 2);
  endtask

  task automatic test_random();
    int bank, row, col, len;
    logic dir;
    for (int i = 0; i < 25; i++) begin
      dir  = 1'($urandom_range(0, 1));
      bank = $urandom_range(0, (1 << BANK_W) - 1);
      row  = ($urandom_range(0, 3) == 0) ? NROW - 1 : $urandom_range(0, NROW - 1);
      col  = ($urandom_range(0, 2) == 0) ? $urandom_range(NCOL - 16, NCOL - 1)
                                         : $urandom_range(0, NCOL - 1);
      len  = $urandom_range(0, 10);
      run_xfer(dir, bank, row, col, len);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_len();
    test_idle_pulses();
    test_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
